ov7670_capture: RTL and testbench

Captures the OV7670 RGB444 byte stream (two bytes per pixel, framed by VSYNC/HREF) in the camera pixel-clock domain. It assembles 12-bit pixels and writes them, one per pixel, into the video frame buffer at linear addresses 0..W*H-1. The buffer's read side is scanned out by the VGA controller. Per-frame status is reported so the system can detect malformed frames.

---
 rtl/ov7670_capture.sv | 170 +++++++++++++++++
 tb/tb_ov7670_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: pairs camera bytes into 12-bit pixels, writes them linearly
// into the frame buffer and reports per-frame line-length / overflow status.
module ov7670_capture #(
    parameter int RESOLUTION_WIDTH  = 640,
    parameter int RESOLUTION_HEIGHT = 480
) (
    input  logic                                                pclk,
    input  logic                                                rst_n,
    input  logic                                                cam_vsync,
    input  logic                                                cam_href,
    input  logic [7:0]                                          cam_data,
    input  logic                                                capture_en,
    output logic                                                w_clk,
    output logic [$clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT):0] w_addr,
    output logic [11:0]                                         w_data,
    output logic                                                w_en,
    output logic                                                frame_done,
    output logic                                                frame_err
);
    localparam int NPIX = RESOLUTION_WIDTH * RESOLUTION_HEIGHT;
    localparam int AW   = $clog2(NPIX) + 1;
    localparam int CW   = $clog2(RESOLUTION_WIDTH) + 1;
    localparam int LW   = $clog2(RESOLUTION_HEIGHT) + 1;

    localparam logic [AW-1:0] ADDR_END  = AW'(NPIX);
    localparam logic [CW-1:0] COL_FULL  = CW'(RESOLUTION_WIDTH);
    localparam logic [LW-1:0] LINE_FULL = LW'(RESOLUTION_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACTIVE
    } state_t;

    state_t state_q, state_d;

    logic          vs_q, vs_q_d, hr_q, hr_q_d;
    logic [7:0]    d_q;
    logic          phase_q;
    logic [3:0]    r_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] col_q, col_inc;
    logic [LW-1:0] line_q, line_inc, lines_now;
    logic          err_q;

    logic vs_fall, vs_rise, hr_fall;
    logic active, pix_valid, line_end, wr_ok, wr_ovf, line_bad, err_now;
    logic start_frame, end_frame;

    assign w_clk = pclk;

    assign vs_fall = vs_q_d & ~vs_q;
    assign vs_rise = ~vs_q_d & vs_q;
    assign hr_fall = hr_q_d & ~hr_q;

    assign active    = (state_q == S_ACTIVE);
    assign pix_valid = active & hr_q & phase_q;
    assign line_end  = active & hr_fall;
    assign wr_ok     = pix_valid & (addr_q != ADDR_END);
    assign wr_ovf    = pix_valid & (addr_q == ADDR_END);

    assign col_inc  = (col_q == '1) ? col_q : col_q + 1'b1;
    assign line_inc = (line_q == '1) ? line_q : line_q + 1'b1;

    // A line ending in the same cycle as the frame is counted before the frame check.
    assign line_bad  = line_end & (col_q != COL_FULL);
    assign lines_now = line_end ? line_inc : line_q;
    assign err_now   = err_q | wr_ovf | line_bad | (lines_now != LINE_FULL);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (capture_en) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!capture_en) begin
                    state_d = S_IDLE;
                end else if (vs_fall) begin
                    state_d     = S_ACTIVE;
                    start_frame = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    end_frame = 1'b1;
                    state_d   = capture_en ? S_ARMED : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every register, including the output strobes, is cleared by the async
    // reset so an aborted frame can never leave a stale write or status pulse behind.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b0;
            vs_q_d     <= 1'b0;
            hr_q       <= 1'b0;
            hr_q_d     <= 1'b0;
            d_q        <= '0;
            phase_q    <= 1'b0;
            r_q        <= '0;
            addr_q     <= '0;
            col_q      <= '0;
            line_q     <= '0;
            err_q      <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            w_en       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vs_q   <= cam_vsync;
            vs_q_d <= vs_q;
            hr_q   <= cam_href;
            hr_q_d <= hr_q;
            d_q    <= cam_data;

            w_en       <= wr_ok;
            frame_done <= end_frame;

            if (wr_ok) begin
                w_addr <= addr_q;
                w_data <= {r_q, d_q};
                addr_q <= addr_q + 1'b1;
            end

            if (start_frame) begin
                phase_q <= 1'b0;
                addr_q  <= '0;
                col_q   <= '0;
                line_q  <= '0;
                err_q   <= 1'b0;
            end else if (active) begin
                if (line_end) begin
                    // A trailing unpaired byte is dropped by clearing the phase.
                    phase_q <= 1'b0;
                    col_q   <= '0;
                    line_q  <= line_inc;
                end else if (hr_q) begin
                    phase_q <= ~phase_q;
                    if (!phase_q) begin
                        r_q <= d_q[3:0];
                    end else begin
                        col_q <= col_inc;
                    end
                end
                if (wr_ovf || line_bad) err_q <= 1'b1;
            end

            if (end_frame) frame_err <= err_now;
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture at W=4, H=3: frame stimulus pushes expected
// writes and frame status; a negedge monitor pops and compares them.
module tb_ov7670_capture;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;
    localparam int AW   = $clog2(NPIX) + 1;

    logic          pclk = 1'b0;
    logic          rst_n;
    logic          cam_vsync, cam_href, capture_en;
    logic [7:0]    cam_data;
    logic          w_clk, w_en, frame_done, frame_err;
    logic [AW-1:0] w_addr;
    logic [11:0]   w_data;

    typedef struct {
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    wr_t wr_q[$];
    bit  fr_q[$];
    bit  last_err;
    bit  w_en_d, fd_d;
    int  n_checks = 0;
    int  n_errors = 0;

    ov7670_capture #(
        .RESOLUTION_WIDTH (W),
        .RESOLUTION_HEIGHT(H)
    ) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .capture_en(capture_en),
        .w_clk     (w_clk),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .w_en      (w_en),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every write and frame_done must match the head of its queue.
    always @(negedge pclk) begin
        if (rst_n) begin
            if (w_en) begin
                check("w_en_rate", 32'(w_en_d), 32'd0);
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(w_en), 32'd0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("w_addr", 32'(w_addr), 32'(e.addr));
                    check("w_data", 32'(w_data), 32'(e.data));
                end
            end
            if (frame_done) begin
                check("fd_width", 32'(fd_d), 32'd0);
                if (fr_q.size() == 0) begin
                    check("fd_unexpected", 32'(frame_done), 32'd0);
                end else begin
                    last_err = fr_q.pop_front();
                    check("frame_err", 32'(frame_err), 32'(last_err));
                end
            end
        end
        w_en_d <= w_en;
        fd_d   <= frame_done;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // One frame of nlines lines; line odd_line carries odd_bytes bytes, others 2*W.
    // capt says whether the DUT should be capturing it; drop_line drops capture_en
    // at that line's start; sync_end ends the last line and the frame together.
    task automatic run_frame(input int nlines, input int odd_line, input int odd_bytes,
                             input bit capt, input int drop_line, input bit fixed,
                             input bit sync_end);
        int        addr = 0;
        bit        err  = 0;
        logic [7:0] b1, b2;
        @(negedge pclk);
        cam_vsync = 1'b1;
        cam_href  = 1'b0;
        idle(4);
        cam_vsync = 1'b0;
        idle(4);
        for (int l = 0; l < nlines; l++) begin
            int nb;
            nb = (l == odd_line) ? odd_bytes : 2 * W;
            if (l == drop_line) capture_en = 1'b0;
            for (int b = 0; b < nb; b++) begin
                @(negedge pclk);
                cam_href = 1'b1;
                if (b % 2 == 0) begin
                    b1 = fixed ? 8'h0A : 8'($urandom);
                    cam_data = b1;
                end else begin
                    b2 = fixed ? 8'h5C : 8'($urandom);
                    cam_data = b2;
                    if (capt) begin
                        if (addr < NPIX) begin
                            wr_q.push_back('{addr: AW'(addr), data: {b1[3:0], b2}});
                            addr++;
                        end else begin
                            err = 1'b1;
                        end
                    end
                end
            end
            if (nb / 2 != W) err = 1'b1;
            if (!(sync_end && l == nlines - 1)) begin
                @(negedge pclk);
                cam_href = 1'b0;
                idle(3);
            end
        end
        if (nlines != H) err = 1'b1;
        @(negedge pclk);
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        if (capt) fr_q.push_back(err);
        idle(6);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && (wr_q.size() != 0 || fr_q.size() != 0); i++) @(negedge pclk);
        check({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
        check({tag, "_fd_left"}, 32'(fr_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b1;
        rst_n      = 1'b0;
        cam_vsync  = 1'b1;
        cam_href   = 1'b0;
        cam_data   = '0;
        capture_en = 1'b0;
        idle(3);
        check("rst_w_en", 32'(w_en), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Clean frames, then the next frame restarts at address 0.
        capture_en = 1'b1;
        run_frame(H, -1, 0, 1, -1, 1, 0);
        run_frame(H, -1, 0, 1, -1, 0, 0);
        drain("clean");

        // Short line, then a clean frame clears the status.
        run_frame(H, 1, 6, 1, -1, 0, 0);
        drain("short");
        idle(5);
        check("err_hold", 32'(frame_err), 32'(last_err));
        run_frame(H, -1, 0, 1, -1, 0, 0);
        drain("recover");

        // Odd byte count and simultaneous line/frame end with a short last line.
        run_frame(H, 0, 9, 1, -1, 0, 0);
        run_frame(H, 2, 4, 1, -1, 0, 1);
        run_frame(H, -1, 0, 1, -1, 0, 1);
        drain("odd_sync");

        // Overflow: four lines of W pixels.
        run_frame(H + 1, -1, 0, 1, -1, 0, 0);
        drain("ovf");

        // Disarmed throughout, then dropped mid-frame, then re-armed.
        capture_en = 1'b0;
        run_frame(H, -1, 0, 0, -1, 0, 0);
        capture_en = 1'b1;
        run_frame(H, -1, 0, 1, 1, 0, 0);
        run_frame(H, -1, 0, 0, -1, 0, 0);
        capture_en = 1'b1;
        run_frame(H, -1, 0, 1, -1, 0, 0);
        drain("arm");

        // Reset during line 1 aborts the frame; capture resumes on a fresh VSYNC fall.
        @(negedge pclk);
        cam_vsync = 1'b1;
        idle(4);
        cam_vsync = 1'b0;
        idle(4);
        for (int p = 0; p < W + 2; p++) begin
            b1 = 8'($urandom);
            @(negedge pclk);
            cam_href = 1'b1;
            cam_data = b1;
            @(negedge pclk);
            cam_data = 8'($urandom);
            wr_q.push_back('{addr: AW'(p), data: {b1[3:0], cam_data}});
            if (p == W - 1) begin
                @(negedge pclk);
                cam_href = 1'b0;
                idle(3);
            end
        end
        @(negedge pclk);
        cam_data = 8'h3C;
        @(negedge pclk);
        cam_data = 8'hC3;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_w_en", 32'(w_en), 32'd0);
        check("mid_rst_w_addr", 32'(w_addr), 32'd0);
        check("mid_rst_w_data", 32'(w_data), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_wr_left", 32'(wr_q.size()), 32'd0);
        idle(2);
        rst_n = 1'b1;
        for (int b = 0; b < 2 + 2 * W; b++) begin
            @(negedge pclk);
            cam_href = (b != 2);
            cam_data = 8'($urandom);
        end
        @(negedge pclk);
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        idle(6);
        run_frame(H, -1, 0, 1, -1, 0, 0);
        drain("reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
